mdu_seq: RTL and testbench

- Sequencer for the multiply/divide resources used by the execute stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and latches the operands.
- Launches the external pipelined multiplier or the iterative divider, stalls the pipeline until the result is available, then issues the HI/LO write.
- Handles flush-annul, divide-by-zero fast path and divider timeout.

---
 rtl/mdu_seq.sv | 176 +++++++++++++++++
 tb/tb_mdu_seq.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mdu_seq
// Purpose  : Multiply/divide sequencer for the execute stage. Latches the
//            operands, launches the pipelined multiplier or the iterative
//            divider, stalls EX until the result is ready, then issues the
//            HI/LO write. Handles flush-annul, divide-by-zero and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_seq #(
  parameter int MUL_LAT     = 3,
  parameter int DIV_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] srca_i,
  input  logic [31:0] srcb_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic [31:0] opa_o,
  output logic [31:0] opb_o,
  output logic        mul_start_o,
  output logic        mul_signed_o,
  input  logic [63:0] mul_result_i,
  output logic        div_start_o,
  output logic        div_signed_o,
  output logic        div_annul_o,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i,
  output logic        hi_we_o,
  output logic        lo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        dz_o,
  output logic        tmo_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DIV_BUSY = 2'd2,
    COMMIT   = 2'd3
  } state_e;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [7:0] MUL_LAT_C = 8'(MUL_LAT);
  localparam logic [7:0] DIV_TMO_C = 8'(DIV_TIMEOUT);

  state_e      state_q;
  logic [7:0]  cnt_q;        // MUL_BUSY: cycles left; DIV_BUSY: current cycle index
  logic [31:0] opa_q, opb_q, hi_q, lo_q;
  logic        mul_start_q, mul_signed_q, div_start_q, div_signed_q, dz_q;

  logic idle, issue, accept, is_mul, mthi, mtlo, div_flush, div_tmo;

  // Decode of the EX instruction; nothing issues while reset is held so
  // every output reads 0 during reset regardless of the EX inputs.
  assign idle      = (state_q == IDLE);
  assign issue     = idle & op_valid_i & ~flush_i & rst;
  assign is_mul    = (op_i == OP_MULT) | (op_i == OP_MULTU);
  assign accept    = issue & (is_mul | (op_i == OP_DIV) | (op_i == OP_DIVU));
  assign mthi      = issue & (op_i == OP_MTHI);
  assign mtlo      = issue & (op_i == OP_MTLO);

  // Flush beats a same-cycle ready; ready beats a same-cycle timeout.
  assign div_flush = (state_q == DIV_BUSY) & flush_i;
  assign div_tmo   = (state_q == DIV_BUSY) & ~flush_i & ~div_ready_i &
                     (cnt_q == DIV_TMO_C);

  assign stall_o      = accept | (state_q == MUL_BUSY) | (state_q == DIV_BUSY);
  assign busy_o       = ~idle;
  assign opa_o        = opa_q;
  assign opb_o        = opb_q;
  assign mul_start_o  = mul_start_q;
  assign mul_signed_o = mul_signed_q;
  assign div_start_o  = div_start_q;
  assign div_signed_o = div_signed_q;
  assign div_annul_o  = div_flush | div_tmo;
  assign tmo_o        = div_tmo;
  assign dz_o         = dz_q;
  // MTHI/MTLO write straight through in the same cycle; mul/div write from
  // the result registers during COMMIT.
  assign hi_we_o      = (state_q == COMMIT) | mthi;
  assign lo_we_o      = (state_q == COMMIT) | mtlo;
  assign hi_o         = mthi ? srca_i : hi_q;
  assign lo_o         = mtlo ? srca_i : lo_q;

  // Sequencer FSM with its registered outputs and operation counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      opa_q        <= 32'd0;
      opb_q        <= 32'd0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      mul_start_q  <= 1'b0;
      mul_signed_q <= 1'b0;
      div_start_q  <= 1'b0;
      div_signed_q <= 1'b0;
      dz_q         <= 1'b0;
    end else begin
      mul_start_q <= 1'b0;
      dz_q        <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            opa_q <= srca_i;
            opb_q <= srcb_i;
            if (is_mul) begin
              state_q      <= MUL_BUSY;
              mul_start_q  <= 1'b1;
              mul_signed_q <= (op_i == OP_MULT);
              cnt_q        <= MUL_LAT_C;
            end else if (srcb_i == 32'd0) begin
              // Divide-by-zero: skip the divider and commit fixed results.
              hi_q    <= srca_i;
              lo_q    <= 32'hFFFF_FFFF;
              dz_q    <= 1'b1;
              state_q <= COMMIT;
            end else begin
              state_q      <= DIV_BUSY;
              div_start_q  <= 1'b1;
              div_signed_q <= (op_i == OP_DIV);
              cnt_q        <= 8'd1;
            end
          end
        end
        MUL_BUSY: begin
          if (flush_i) begin
            state_q <= IDLE;
          end else if (cnt_q == 8'd1) begin
            hi_q    <= mul_result_i[63:32];
            lo_q    <= mul_result_i[31:0];
            state_q <= COMMIT;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        DIV_BUSY: begin
          if (flush_i) begin
            state_q     <= IDLE;
            div_start_q <= 1'b0;
          end else if (div_ready_i) begin
            hi_q        <= div_result_i[63:32];
            lo_q        <= div_result_i[31:0];
            state_q     <= COMMIT;
            div_start_q <= 1'b0;
          end else if (cnt_q == DIV_TMO_C) begin
            state_q     <= IDLE;
            div_start_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        COMMIT: begin
          // The write is older than any flush arriving now; it always retires.
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mdu_seq
// Purpose  : Self-checking bench for mdu_seq with a behavioural multiplier,
//            divider and transaction-level expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_seq;

  localparam int MUL_LAT     = 3;
  localparam int DIV_TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid_i;
  logic [2:0]  op_i;
  logic [31:0] srca_i, srcb_i;
  logic        flush_i;
  logic        stall_o, busy_o;
  logic [31:0] opa_o, opb_o;
  logic        mul_start_o, mul_signed_o;
  logic [63:0] mul_result_i;
  logic        div_start_o, div_signed_o, div_annul_o, div_ready_i;
  logic [63:0] div_result_i;
  logic        hi_we_o, lo_we_o;
  logic [31:0] hi_o, lo_o;
  logic        dz_o, tmo_o;

  always #5 clk = ~clk;

  mdu_seq #(.MUL_LAT(MUL_LAT), .DIV_TIMEOUT(DIV_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .op_valid_i(op_valid_i), .op_i(op_i),
    .srca_i(srca_i), .srcb_i(srcb_i), .flush_i(flush_i),
    .stall_o(stall_o), .busy_o(busy_o), .opa_o(opa_o), .opb_o(opb_o),
    .mul_start_o(mul_start_o), .mul_signed_o(mul_signed_o),
    .mul_result_i(mul_result_i), .div_start_o(div_start_o),
    .div_signed_o(div_signed_o), .div_annul_o(div_annul_o),
    .div_ready_i(div_ready_i), .div_result_i(div_result_i),
    .hi_we_o(hi_we_o), .lo_we_o(lo_we_o), .hi_o(hi_o), .lo_o(lo_o),
    .dz_o(dz_o), .tmo_o(tmo_o)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference arithmetic: {hi,lo} product and {remainder,quotient}.
  function automatic logic [63:0] mul_ref(input logic [31:0] a, b, input logic sgn);
    longint sa, sb;
    logic [63:0] ua, ub;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  function automatic logic [63:0] div_ref(input logic [31:0] a, b, input logic sgn);
    int sa, sb;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = a;
      sb = b;
      return {32'(sa % sb), 32'(sa / sb)};
    end
    return {a % b, a / b};
  endfunction

  // Environment: multiplier result valid MUL_LAT cycles after the start pulse
  // (garbage otherwise); divider ready after ready_after start cycles.
  int   dcnt = 0;
  int   mcnt = 0;
  int   ready_after = 0;
  logic force_ready = 1'b0;

  always @(posedge clk) begin
    if (div_start_o) dcnt <= dcnt + 1; else dcnt <= 0;
    if (mul_start_o) mcnt <= 1;
    else if (mcnt != 0 && mcnt < 1000) mcnt <= mcnt + 1;
  end

  assign mul_result_i = (mcnt == MUL_LAT - 1) ? mul_ref(opa_o, opb_o, mul_signed_o)
                                              : 64'hBAD0_BAD0_BAD0_BAD0;
  assign div_ready_i  = (div_start_o && (dcnt + 1 == ready_after)) || force_ready;
  assign div_result_i = div_ref(opa_o, opb_o, div_signed_o);

  // Event counters: 0 hi_we, 1 lo_we, 2 annul, 3 tmo, 4 dz, 5 div_start, 6 mul_start, 7 stall
  int mon [8];
  int snap [8];
  initial for (int i = 0; i < 8; i++) mon[i] = 0;
  always @(negedge clk) begin
    if (hi_we_o)     mon[0]++;
    if (lo_we_o)     mon[1]++;
    if (div_annul_o) mon[2]++;
    if (tmo_o)       mon[3]++;
    if (dz_o)        mon[4]++;
    if (div_start_o) mon[5]++;
    if (mul_start_o) mon[6]++;
    if (stall_o)     mon[7]++;
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, {stall_o, busy_o, mul_start_o, mul_signed_o, div_start_o,
        div_signed_o, div_annul_o, hi_we_o, lo_we_o, dz_o, tmo_o}, 64'd0);
    chk({tag, "_hilo"}, {hi_o, lo_o}, 64'd0);
    chk({tag, "_ops"}, {opa_o, opb_o}, 64'd0);
  endtask

  // One mul/div transaction; called at posedge+1 with the DUT in IDLE.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, b,
                       input int rdy, input bit fl_commit);
    bit          is_mul;
    bit          sgn;
    bit          dz;
    bit          done;
    bit          sgn_seen;
    logic [63:0] exp;
    int          exp_stall;
    int          s [8];
    is_mul    = (op == 3'd1 || op == 3'd2);
    sgn       = (op == 3'd1 || op == 3'd3);
    dz        = !is_mul && (b == 32'd0);
    done      = 1'b0;
    sgn_seen  = 1'b0;
    exp       = is_mul ? mul_ref(a, b, sgn) : dz ? {a, 32'hFFFF_FFFF} : div_ref(a, b, sgn);
    exp_stall = is_mul ? MUL_LAT + 1 : dz ? 1 : rdy + 1;
    ready_after = rdy;
    s = mon;
    op_valid_i = 1'b1; op_i = op; srca_i = a; srcb_i = b; flush_i = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (cyc == 0) chk("accept_stall", 64'(stall_o), 64'd1);
      if (!sgn_seen && (mul_start_o || div_start_o)) begin
        sgn_seen = 1'b1;
        chk("signed_flag", 64'(is_mul ? mul_signed_o : div_signed_o), 64'(sgn));
      end
      if (hi_we_o && lo_we_o) begin
        done = 1'b1;
        chk("latency", 64'(cyc), 64'(exp_stall));
        chk("hilo", {hi_o, lo_o}, exp);
        chk("commit_stall", 64'(stall_o), 64'd0);
        chk("dz_at_commit", 64'(dz_o), 64'(dz));
        chk("operands", {opa_o, opb_o}, {a, b});
        break;
      end
      @(posedge clk); #1;
      op_i = 3'($urandom); srca_i = $urandom; srcb_i = $urandom;
      flush_i = fl_commit && (cyc + 1 == exp_stall);
    end
    if (!done) chk("commit_seen", 64'd0, 64'd1);
    @(posedge clk); #1;
    op_valid_i = 1'b0; op_i = 3'd0; flush_i = 1'b0;
    chk("n_stall", 64'(mon[7] - s[7]), 64'(exp_stall));
    chk("n_mul_start", 64'(mon[6] - s[6]), 64'(is_mul));
    chk("n_div_start", 64'(mon[5] - s[5]), 64'((is_mul || dz) ? 0 : rdy));
    chk("n_dz", 64'(mon[4] - s[4]), 64'(dz));
    chk("n_annul_tmo", 64'(mon[2] - s[2] + mon[3] - s[3]), 64'd0);
    chk("n_we", 64'(mon[0] - s[0] + mon[1] - s[1]), 64'd2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    rst = 1'b0; op_valid_i = 1'b0; op_i = 3'd0; srca_i = 32'd0; srcb_i = 32'd0;
    flush_i = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // Directed transactions
    do_op(3'd1, 32'hFFFF_FFFE, 32'd3, 0, 1'b0);   // MULT -2*3
    do_op(3'd4, 32'd100, 32'd7, 33, 1'b0);        // DIVU 100/7
    do_op(3'd3, 32'd5, 32'd0, 0, 1'b0);           // DIV 5/0
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1);  // MULTU, flush in COMMIT
    do_op(3'd3, 32'hFFFF_FF9C, 32'd7, 5, 1'b1);   // DIV -100/7, flush in COMMIT
    do_op(3'd4, 32'd9, 32'd4, 1, 1'b0);           // ready in first busy cycle

    // Flush on the 10th DIV_BUSY cycle, then a stray late ready
    snap = mon; ready_after = 20;
    op_valid_i = 1'b1; op_i = 3'd3; srca_i = 32'd50; srcb_i = 32'd5;
    @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      op_i = 3'($urandom); srca_i = $urandom; srcb_i = $urandom;
      if (k == 10) flush_i = 1'b1;
      @(negedge clk);
      if (k == 10) begin
        chk("flush_annul", 64'(div_annul_o), 64'd1);
        chk("flush_start_held", 64'(div_start_o), 64'd1);
        chk("flush_tmo", 64'(tmo_o), 64'd0);
      end
    end
    @(posedge clk); #1 flush_i = 1'b0; op_valid_i = 1'b0; op_i = 3'd0;
    @(negedge clk);
    chk("flush_released", {stall_o, busy_o, div_start_o, div_annul_o}, 64'd0);
    @(posedge clk); #1 force_ready = 1'b1;
    @(negedge clk);
    chk("late_ready_ignored", {hi_we_o, lo_we_o, busy_o}, 64'd0);
    @(posedge clk); #1 force_ready = 1'b0;
    @(posedge clk); #1;
    chk("flush_n_we", 64'(mon[0] + mon[1] - snap[0] - snap[1]), 64'd0);
    chk("flush_n_annul", 64'(mon[2] - snap[2]), 64'd1);
    chk("flush_n_div_start", 64'(mon[5] - snap[5]), 64'd10);

    // Flush during MUL_BUSY
    snap = mon;
    op_valid_i = 1'b1; op_i = 3'd2; srca_i = 32'd7; srcb_i = 32'd9;
    @(posedge clk); #1;
    @(posedge clk); #1 flush_i = 1'b1;
    @(negedge clk);
    chk("mflush_stall", 64'(stall_o), 64'd1);
    @(posedge clk); #1 flush_i = 1'b0; op_valid_i = 1'b0;
    @(negedge clk);
    chk("mflush_released", {stall_o, busy_o, hi_we_o, lo_we_o}, 64'd0);
    repeat (3) @(posedge clk); #1;
    chk("mflush_n_we", 64'(mon[0] + mon[1] - snap[0] - snap[1]), 64'd0);

    // Divider timeout
    snap = mon; ready_after = 0; found = 1'b0;
    op_valid_i = 1'b1; op_i = 3'd4; srca_i = 32'd123; srcb_i = 32'd9;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (tmo_o) begin
        found = 1'b1;
        chk("tmo_cycle", 64'(k), 64'(DIV_TIMEOUT));
        chk("tmo_annul", 64'(div_annul_o), 64'd1);
        break;
      end
      @(posedge clk); #1;
      op_i = 3'($urandom); srca_i = $urandom; srcb_i = $urandom;
    end
    if (!found) chk("tmo_seen", 64'd0, 64'd1);
    @(posedge clk); #1 op_valid_i = 1'b0; op_i = 3'd0;
    @(negedge clk);
    chk("tmo_released", {stall_o, busy_o, div_start_o, tmo_o, div_annul_o}, 64'd0);
    @(posedge clk); #1;
    chk("tmo_n_we", 64'(mon[0] + mon[1] - snap[0] - snap[1]), 64'd0);
    chk("tmo_n_pulses", 64'({mon[2] - snap[2], mon[3] - snap[3]}), {32'd1, 32'd1});

    // MTLO / MTHI / flushed MTLO / reserved opcode
    op_valid_i = 1'b1; op_i = 3'd6; srca_i = 32'h1234;
    @(negedge clk);
    chk("mtlo_ctrl", {lo_we_o, hi_we_o, stall_o, busy_o}, 64'b1000);
    chk("mtlo_data", 64'(lo_o), 64'h1234);
    @(posedge clk); #1 flush_i = 1'b1;
    @(negedge clk);
    chk("mtlo_flushed", {lo_we_o, hi_we_o, stall_o}, 64'd0);
    @(posedge clk); #1 flush_i = 1'b0; op_i = 3'd5; srca_i = 32'hCAFE_0001;
    @(negedge clk);
    chk("mthi_ctrl", {hi_we_o, lo_we_o, stall_o}, 64'b100);
    chk("mthi_data", 64'(hi_o), 64'hCAFE_0001);
    @(posedge clk); #1 op_i = 3'd7;
    @(negedge clk);
    chk("reserved_op", {hi_we_o, lo_we_o, stall_o, busy_o}, 64'd0);
    @(posedge clk); #1 op_valid_i = 1'b0; op_i = 3'd0;
    @(negedge clk);
    chk("reserved_idle", 64'(busy_o), 64'd0);
    @(posedge clk); #1;

    // Randomized transactions
    for (int i = 0; i < 16; i++) begin
      rop = 3'($urandom_range(1, 4));
      ra  = $urandom;
      rb  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 50));
      if (rop >= 3'd3 && $urandom_range(0, 3) == 0) rb = 32'd0;
      if (rop == 3'd3 && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
      do_op(rop, ra, rb, $urandom_range(1, 30), bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // Reset in the middle of a multiply
    op_valid_i = 1'b1; op_i = 3'd1; srca_i = 32'h11; srcb_i = 32'h22;
    @(posedge clk); #1;
    @(posedge clk); #3 rst = 1'b0;
    #1 chk_all_zero("midrst");
    op_valid_i = 1'b0; op_i = 3'd0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    do_op(3'd1, 32'd6, 32'd7, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
